collatz_sweep_ctrl: RTL and testbench
=====================================

// Module: collatz_sweep_ctrl
// PURPOSE
//   Sequences the Collatz step-counter core over a range of starting values [lo..hi].
//   Issues one start pulse per value and waits out the core's busy window.
//   Captures each step count and reports the value with the largest count.
//   Sits between the host/IO pins and the core; it is the only driver of the core's start and N inputs.
// PARAMETERS
//   NW             8   width of starting value N (lo, hi, core_n, best_n, cur_n)
//   CW             8   width of core step count (core_steps, best_steps)
//   START_TIMEOUT  4   max cycles after core_start to wait for core_busy=1 before flagging err
// PORTS
//   clk         in   1    single clock; all logic on rising edge
//   rst         in   1    synchronous reset, active-high
//   sweep_go    in   1    start request; honoured only in IDLE or DONE
//   lo          in   NW   first N of the sweep; sampled the cycle sweep_go is accepted
//   hi          in   NW   last N of the sweep (inclusive); sampled with lo
//   core_start  out  1    one-cycle start pulse to the core
//   core_n      out  NW   N presented to the core; stable from LAUNCH until the next LAUNCH
//   core_busy   in   1    core busy flag
//   core_steps  in   CW   core step count; valid when core_busy falls
//   busy        out  1    sweep in progress (any state other than IDLE/DONE)
//   done        out  1    sweep finished; held high until the next accepted sweep_go
//   err         out  1    range invalid or core start timeout; valid while done=1
//   best_n      out  NW   N with the largest step count so far
//   best_steps  out  CW   largest step count so far
//   cur_n       out  NW   N currently being processed
// BEHAVIOUR
//   Reset: state=IDLE; every output is 0; the timeout counter is cleared. Reset mid-sweep aborts immediately, and core_start is 0 in the cycle after reset.
//   States: IDLE, LAUNCH, ARM, RUN, UPDATE, DONE.
//   IDLE/DONE + sweep_go:
//     - latch lo/hi; clear done, err, best_n, best_steps.
//     - if lo==0 or lo>hi: go to DONE with err=1; core_start is never pulsed.
//     - otherwise cur_n=lo and go to LAUNCH; busy=1 from the next cycle.
//   sweep_go in any other state: ignored.
//   LAUNCH (1 cycle): core_start=1, core_n=cur_n; clear the timeout counter; go to ARM.
//   ARM: wait for core_busy=1, then go to RUN.
//     - the timeout counter increments each cycle that core_busy=0.
//     - when the counter reaches START_TIMEOUT: err=1, go to DONE; best_* keep their current values.
//   RUN: wait for core_busy=0. In that cycle, register core_steps and go to UPDATE.
//   UPDATE (1 cycle):
//     - if captured steps > best_steps (strictly greater), load best_n=cur_n and best_steps=steps. On a tie, the smaller N is kept.
//     - if cur_n==hi: go to DONE. Otherwise cur_n=cur_n+1 and go to LAUNCH.
//     - the cur_n==hi comparison is made before the increment, so hi=2^NW-1 never wraps cur_n to 0.
//   DONE: done=1, busy=0; best_*, cur_n and err are held.
//   Latency:
//     - sweep_go accepted at cycle t gives core_start=1 at t+1.
//     - per-value overhead is 3 cycles (LAUNCH, UPDATE, plus at least 1 ARM cycle) on top of the core's busy time.
//     - done rises the cycle after the final UPDATE.
//   The first value always sets best_* (its steps are compared against 0, except a 0-step value, which leaves best_n=0).
//   core_start is never high in two consecutive cycles, and never high outside LAUNCH.
// TESTING (bench uses a behavioural core model: busy rises 1 cycle after start and lasts steps+1 cycles)
//   1. lo=1, hi=10 -> 10 core_start pulses with core_n 1..10; done=1, best_n=9, best_steps=19, err=0.
//   2. lo=12, hi=13 (both 9 steps) -> tie keeps best_n=12, best_steps=9.
//   3. lo=5, hi=3, then separately lo=0, hi=4 -> done=1, err=1 the cycle after go; zero core_start pulses.
//   4. lo=hi=255 -> exactly one core_start; done=1 and cur_n=255 (no wrap to 0); sweep_go during RUN is ignored.
//   5. model never raises busy -> err=1 and done=1 exactly START_TIMEOUT cycles after ARM is entered.
//   6. rst=1 during RUN of lo=1, hi=10 -> next cycle all outputs 0 and state IDLE; a new go with lo=3, hi=3 gives best_n=3, best_steps=7.

Source files
------------

// File: rtl/collatz_sweep_ctrl_if.sv
// Core-facing handshake between the sweep controller and the Collatz step-counter core.
//   core_start  controller -> core  one-cycle start pulse
//   core_n      controller -> core  starting value N, held between launches
//   core_busy   core -> controller  core is iterating
//   core_steps  core -> controller  step count, valid when core_busy falls
// The master modport is the controller side, the slave modport is the core side.
interface collatz_sweep_ctrl_if #(
  parameter int NW = 8,
  parameter int CW = 8
);
  logic          core_start;
  logic [NW-1:0] core_n;
  logic          core_busy;
  logic [CW-1:0] core_steps;

  modport master (output core_start, core_n, input core_busy, core_steps);
  modport slave  (input core_start, core_n, output core_busy, core_steps);
endinterface

// File: rtl/collatz_sweep_ctrl.sv
// Sweeps the Collatz step-counter core over every N in [lo..hi], one start
// pulse per value, and keeps the N with the largest step count.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   sweep_go        start request, accepted only when idle or done
//   lo, hi          inclusive sweep range, sampled when sweep_go is accepted
//   core            core handshake (start/N out, busy/steps in)
//   busy, done, err sweep status; err means bad range or core start timeout
//   best_n          N with the largest step count so far
//   best_steps      that largest step count
//   cur_n           N currently being processed
module collatz_sweep_ctrl #(
  parameter int NW            = 8,
  parameter int CW            = 8,
  parameter int START_TIMEOUT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sweep_go,
  input  logic [NW-1:0]               lo,
  input  logic [NW-1:0]               hi,
  collatz_sweep_ctrl_if.master        core,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [NW-1:0]               best_n,
  output logic [CW-1:0]               best_steps,
  output logic [NW-1:0]               cur_n
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_ARM    = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int            TW       = $clog2(START_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);

  logic [2:0]    state_reg, state_next;
  logic [NW-1:0] hi_reg, hi_next;
  logic [NW-1:0] cur_n_reg, cur_n_next;
  logic [NW-1:0] core_n_reg, core_n_next;
  logic [CW-1:0] steps_reg, steps_next;
  logic [NW-1:0] best_n_reg, best_n_next;
  logic [CW-1:0] best_steps_reg, best_steps_next;
  logic          err_reg, err_next;
  logic [TW-1:0] tmo_reg, tmo_next;

  always_comb begin
    state_next      = state_reg;
    hi_next         = hi_reg;
    cur_n_next      = cur_n_reg;
    core_n_next     = core_n_reg;
    steps_next      = steps_reg;
    best_n_next     = best_n_reg;
    best_steps_next = best_steps_reg;
    err_next        = err_reg;
    tmo_next        = tmo_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (sweep_go) begin
          hi_next         = hi;
          best_n_next     = '0;
          best_steps_next = '0;
          err_next        = 1'b0;
          if (lo == '0 || lo > hi) begin
            // Bad range: report immediately, the core is never started.
            err_next   = 1'b1;
            state_next = S_DONE;
          end else begin
            cur_n_next  = lo;
            core_n_next = lo;
            state_next  = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        tmo_next   = '0;
        state_next = S_ARM;
      end
      S_ARM: begin
        if (core.core_busy) begin
          state_next = S_RUN;
        end else begin
          tmo_next = tmo_reg + 1'b1;
          // This cycle is the START_TIMEOUT-th without busy: give up.
          if (tmo_reg == TMO_LAST) begin
            err_next   = 1'b1;
            state_next = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (!core.core_busy) begin
          steps_next = core.core_steps;
          state_next = S_UPDATE;
        end
      end
      S_UPDATE: begin
        // Strictly greater, so on a tie the earlier (smaller) N survives.
        if (steps_reg > best_steps_reg) begin
          best_n_next     = cur_n_reg;
          best_steps_next = steps_reg;
        end
        // Compare before incrementing so hi = all-ones never wraps cur_n.
        if (cur_n_reg == hi_reg) begin
          state_next = S_DONE;
        end else begin
          cur_n_next  = cur_n_reg + 1'b1;
          core_n_next = cur_n_reg + 1'b1;
          state_next  = S_LAUNCH;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      hi_reg         <= '0;
      cur_n_reg      <= '0;
      core_n_reg     <= '0;
      steps_reg      <= '0;
      best_n_reg     <= '0;
      best_steps_reg <= '0;
      err_reg        <= 1'b0;
      tmo_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      hi_reg         <= hi_next;
      cur_n_reg      <= cur_n_next;
      core_n_reg     <= core_n_next;
      steps_reg      <= steps_next;
      best_n_reg     <= best_n_next;
      best_steps_reg <= best_steps_next;
      err_reg        <= err_next;
      tmo_reg        <= tmo_next;
    end
  end

  // The start pulse is decoded from the one-cycle LAUNCH state, so it can
  // never be high twice in a row nor anywhere else.
  assign core.core_start = (state_reg == S_LAUNCH);
  assign core.core_n     = core_n_reg;
  assign busy            = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done            = (state_reg == S_DONE);
  assign err             = err_reg;
  assign best_n          = best_n_reg;
  assign best_steps      = best_steps_reg;
  assign cur_n           = cur_n_reg;
endmodule

// File: tb/tb_collatz_sweep_ctrl.sv
module tb_collatz_sweep_ctrl;
  localparam int NW  = 8;
  localparam int CW  = 8;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          sweep_go;
  logic [NW-1:0] lo, hi;
  logic          busy, done, err;
  logic [NW-1:0] best_n, cur_n;
  logic [CW-1:0] best_steps;

  always #5 clk = ~clk;

  collatz_sweep_ctrl_if #(.NW(NW), .CW(CW)) cif ();

  collatz_sweep_ctrl #(.NW(NW), .CW(CW), .START_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .sweep_go   (sweep_go),
    .lo         (lo),
    .hi         (hi),
    .core       (cif),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .best_n     (best_n),
    .best_steps (best_steps),
    .cur_n      (cur_n)
  );

  // Reference Collatz step count: iterations until the value reaches 1.
  function automatic int collatz(input int n);
    int s = 0;
    while (n > 1) begin
      n = (n % 2 != 0) ? 3 * n + 1 : n / 2;
      s++;
    end
    return s;
  endfunction

  // Behavioural core: busy rises 1 cycle after start and lasts steps+1 cycles.
  int            rem = 0;
  logic [CW-1:0] steps_out = '0;
  bit            model_dead = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      rem <= 0;
    end else if (cif.core_start && !model_dead) begin
      rem       <= collatz(int'(cif.core_n)) + 1;
      steps_out <= CW'(collatz(int'(cif.core_n)));
    end else if (rem > 0) begin
      rem <= rem - 1;
    end
  end
  assign cif.core_busy  = (rem > 0);
  assign cif.core_steps = steps_out;

  // Start-pulse monitor: logs every launched N and counts back-to-back pulses.
  int            start_cnt = 0;
  int            dbl_start = 0;
  logic          prev_start = 1'b0;
  logic [NW-1:0] start_log [1024];
  always @(negedge clk) begin
    if (cif.core_start === 1'b1) begin
      start_log[start_cnt % 1024] = cif.core_n;
      start_cnt++;
      if (prev_start) dbl_start++;
    end
    prev_start = cif.core_start;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d expected %0d", tag, name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_go(input int l, input int h);
    lo       = NW'(l);
    hi       = NW'(h);
    sweep_go = 1'b1;
    step();
    sweep_go = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (!done && cyc < 5000) begin
      step();
      cyc++;
    end
    if (!done) chk(tag, "done_timeout", 0, 1);
  endtask

  // Expected result of a whole sweep, straight from the range definition.
  task automatic model_sweep(input int l, input int h, output int bn, output int bs, output int cyc);
    bn  = 0;
    bs  = 0;
    cyc = 0;
    for (int n = l; n <= h; n++) begin
      int s = collatz(n);
      if (s > bs) begin
        bs = s;
        bn = n;
      end
      cyc += s + 4;
    end
  endtask

  task automatic run_sweep(input string tag, input int l, input int h,
                           input int exp_bn, input int exp_bs, input int exp_err);
    int base, cyc, m_bn, m_bs, m_cyc, n_exp;
    base  = start_cnt;
    n_exp = exp_err ? 0 : h - l + 1;
    model_sweep(l, h, m_bn, m_bs, m_cyc);
    do_go(l, h);
    if (exp_err != 0) begin
      chk(tag, "done_next", int'(done), 1);
      chk(tag, "err_next", int'(err), 1);
      step();
      step();
    end else begin
      chk(tag, "start_lat", int'(cif.core_start), 1);
      chk(tag, "busy", int'(busy), 1);
      wait_done(tag, cyc);
      chk(tag, "cycles", cyc, m_cyc);
      chk(tag, "cur_n", int'(cur_n), h);
    end
    chk(tag, "done", int'(done), 1);
    chk(tag, "busy_end", int'(busy), 0);
    chk(tag, "err", int'(err), exp_err);
    chk(tag, "best_n", int'(best_n), exp_bn);
    chk(tag, "best_steps", int'(best_steps), exp_bs);
    chk(tag, "starts", start_cnt - base, n_exp);
    if (start_cnt - base == n_exp) begin
      for (int k = 0; k < n_exp; k++)
        chk(tag, "core_n_seq", int'(start_log[(base + k) % 1024]), l + k);
    end
  endtask

  typedef struct {
    string tag;
    int    lo;
    int    hi;
    int    exp_bn;
    int    exp_bs;
    int    exp_err;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int base, cyc, bn, bs, mc, l, h;
    vecs[0] = '{"range1_10", 1, 10, 9, 19, 0};
    vecs[1] = '{"tie12_13", 12, 13, 12, 9, 0};
    vecs[2] = '{"lo_gt_hi", 5, 3, 0, 0, 1};
    vecs[3] = '{"lo_zero", 0, 4, 0, 0, 1};
    vecs[4] = '{"single3", 3, 3, 3, 7, 0};

    rst = 1'b1; sweep_go = 1'b0; lo = '0; hi = '0;
    repeat (3) step();
    chk("reset", "busy", int'(busy), 0);
    chk("reset", "done", int'(done), 0);
    chk("reset", "err", int'(err), 0);
    chk("reset", "best_n", int'(best_n), 0);
    chk("reset", "best_steps", int'(best_steps), 0);
    chk("reset", "cur_n", int'(cur_n), 0);
    chk("reset", "core_start", int'(cif.core_start), 0);
    chk("reset", "core_n", int'(cif.core_n), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++)
      run_sweep(vecs[i].tag, vecs[i].lo, vecs[i].hi, vecs[i].exp_bn, vecs[i].exp_bs, vecs[i].exp_err);

    // Randomised ranges against the range-level model.
    for (int i = 0; i < 6; i++) begin
      l = int'($urandom_range(1, 60));
      h = l + int'($urandom_range(0, 6));
      model_sweep(l, h, bn, bs, mc);
      run_sweep("random", l, h, bn, bs, 0);
    end

    // Top of range: no wrap, and a go during RUN is ignored.
    base = start_cnt;
    model_sweep(255, 255, bn, bs, mc);
    do_go(255, 255);
    repeat (5) step();
    lo = 8'd1; hi = 8'd2; sweep_go = 1'b1;
    step();
    sweep_go = 1'b0;
    chk("top255", "busy_after_go", int'(busy), 1);
    wait_done("top255", cyc);
    chk("top255", "starts", start_cnt - base, 1);
    chk("top255", "cur_n", int'(cur_n), 255);
    chk("top255", "best_n", int'(best_n), bn);
    chk("top255", "best_steps", int'(best_steps), bs);
    chk("top255", "err", int'(err), 0);

    // Core never answers: timeout exactly TMO cycles after ARM entry.
    model_dead = 1'b1;
    base = start_cnt;
    do_go(7, 9);
    step();
    chk("timeout", "busy_arm", int'(busy), 1);
    repeat (TMO - 1) step();
    chk("timeout", "done_early", int'(done), 0);
    step();
    chk("timeout", "done", int'(done), 1);
    chk("timeout", "err", int'(err), 1);
    chk("timeout", "best_n", int'(best_n), 0);
    chk("timeout", "best_steps", int'(best_steps), 0);
    chk("timeout", "starts", start_cnt - base, 1);
    model_dead = 1'b0;
    step();

    // Reset in the middle of a sweep, then a fresh sweep.
    do_go(1, 10);
    repeat (12) step();
    chk("midrst", "busy_before", int'(busy), 1);
    rst = 1'b1;
    step();
    chk("midrst", "busy", int'(busy), 0);
    chk("midrst", "done", int'(done), 0);
    chk("midrst", "err", int'(err), 0);
    chk("midrst", "best_n", int'(best_n), 0);
    chk("midrst", "best_steps", int'(best_steps), 0);
    chk("midrst", "cur_n", int'(cur_n), 0);
    chk("midrst", "core_start", int'(cif.core_start), 0);
    rst = 1'b0;
    step();
    run_sweep("after_rst", 3, 3, 3, 7, 0);

    chk("monitor", "double_start", dbl_start, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
